program_sequencer: RTL

//  Initiator side of the core's req/ack "do next program" handshake: drives core reset and req,

---
 rtl/proc_pkg.sv | 19 +
 rtl/seq_result_buf.sv | 44 ++++
 rtl/program_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the program sequencer and its result buffer.
package proc_pkg;

  // Sequencer FSM states, in the order a run walks through them.
  typedef enum logic [2:0] {
    IDLE,
    RST,
    REQ,
    DROP,
    RUN,
    REC,
    DONE,
    ERROR
  } seq_state_t;

  // The core raises core_ack while its PC sits at this halt address.
  localparam logic [8:0] HALT_PC = 9'h1FF;

endpackage

// File: rtl/seq_result_buf.sv
// Per-program cycle-count store: one write port, one combinational read
// port, cleared by the asynchronous reset. Out-of-range reads return zero.
module seq_result_buf #(
  parameter int NUM_PROGS = 3,
  parameter int CW        = 16,
  parameter int IW        = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [CW-1:0] wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [CW-1:0] rd_data
);

  logic [CW-1:0] mem_q [NUM_PROGS];
  logic [CW-1:0] mem_d [NUM_PROGS];

  // Next contents: only the addressed entry takes the write data.
  always_comb begin
    for (int i = 0; i < NUM_PROGS; i++) begin
      mem_d[i] = (wr_en && (wr_idx == IW'(i))) ? wr_data : mem_q[i];
    end
  end

  // Storage, cleared whenever the sequencer is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PROGS; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PROGS; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Read mux; an index with no matching entry reads as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (rd_idx == IW'(i)) rd_data = mem_q[i];
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Drives the core's req/ack "do next program" handshake for NUM_PROGS
// programs per run and records each program's cycle count.
//
// Handshake: core_req is a one-cycle pulse. After it, the sequencer first
// waits for core_ack to be low (a level left high by the previous program is
// stale), then waits for core_ack high, which marks the program finished.
// core_ack is sampled every cycle in DROP/RUN and ignored in all other states.
module program_sequencer
  import proc_pkg::*;
#(
  parameter int          NUM_PROGS  = 3,
  parameter int          CW         = 16,
  parameter int unsigned TIMEOUT    = 'hFFF,
  parameter int          RST_CYCLES = 2,
  parameter int          IW         = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_ack,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [IW-1:0] prog_idx,
  output logic          res_valid,
  input  logic [IW-1:0] rd_idx,
  output logic [CW-1:0] rd_count,
  output seq_state_t    state_dbg
);

  localparam int            RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO      = CW'(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PROGS - 1);

  seq_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [IW-1:0] prog_idx_q, prog_idx_d;
  logic          core_reset_q, core_reset_d;
  logic          core_req_q, core_req_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          res_valid_q, res_valid_d;
  logic          wr_en;

  // Next-state and next-output logic; outputs are decided on the transition
  // so every output is a flop.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rst_cnt_d    = rst_cnt_q;
    prog_idx_d   = prog_idx_q;
    core_reset_d = 1'b0;
    core_req_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    res_valid_d  = 1'b0;
    wr_en        = 1'b0;
    // Saturating increment: the count sticks at TIMEOUT, never wraps.
    cnt_inc      = (cnt_q >= TMO) ? TMO : cnt_q + CW'(1);

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d      = RST;
          core_reset_d = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          prog_idx_d   = '0;
          cnt_d        = '0;
          rst_cnt_d    = '0;
        end
      end
      RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d    = REQ;
          core_req_d = 1'b1;
          cnt_d      = '0;
        end else begin
          rst_cnt_d    = rst_cnt_q + RW'(1);
          core_reset_d = 1'b1;
        end
      end
      REQ: begin
        state_d = DROP;
        cnt_d   = '0;
      end
      DROP: begin
        cnt_d = cnt_inc;
        if (!core_ack) begin
          state_d = RUN;
        end else if (cnt_inc == TMO) begin
          state_d = ERROR;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (core_ack) begin
          // The buffer is written on this edge so rd_count already holds
          // the new value while res_valid is high.
          state_d     = REC;
          res_valid_d = 1'b1;
          wr_en       = 1'b1;
        end else if (cnt_inc == TMO) begin
          state_d = ERROR;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end
      end
      REC: begin
        if (prog_idx_q == LAST_IDX) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d    = REQ;
          prog_idx_d = prog_idx_q + IW'(1);
          core_req_d = 1'b1;
          cnt_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rst_cnt_q    <= '0;
      prog_idx_q   <= '0;
      core_reset_q <= 1'b0;
      core_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      prog_idx_q   <= prog_idx_d;
      core_reset_q <= core_reset_d;
      core_req_q   <= core_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      res_valid_q  <= res_valid_d;
    end
  end

  seq_result_buf #(
    .NUM_PROGS (NUM_PROGS),
    .CW        (CW),
    .IW        (IW)
  ) u_result_buf (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (wr_en),
    .wr_idx  (prog_idx_q),
    .wr_data (cnt_d),
    .rd_idx  (rd_idx),
    .rd_data (rd_count)
  );

  assign core_reset = core_reset_q;
  assign core_req   = core_req_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign prog_idx   = prog_idx_q;
  assign res_valid  = res_valid_q;
  assign state_dbg  = state_q;

endmodule
